// File: rtl/ccff_bitstream_loader.sv
// Serializes parallel configuration words onto a config-chain head with a per-bit
// shift enable, counting the ones that leave the chain tail.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 65,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  tail_ones
);

  localparam int REM_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(CHAIN_LEN - 1);
  localparam logic [REM_W-1:0] REM_FULL = REM_W'(WORD_W);
  localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] buf_q;
  logic [REM_W-1:0]  rem_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              in_shift, buf_empty, last_bit, accept;

  // abort cancels the current cycle's shift too, so the chain stops where it is
  always_comb begin
    in_shift      = (state_q == S_SHIFT);
    buf_empty     = (rem_q == '0);
    ccff_shift_en = in_shift && !abort && !buf_empty && (cnt_q < LIMIT);
    last_bit      = ccff_shift_en && (cnt_q == LAST);
    word_ready    = in_shift && !abort && !last_bit &&
                    (buf_empty || (rem_q == REM_ONE && ccff_shift_en));
    accept        = word_valid && word_ready;
    ccff_head     = ccff_shift_en & buf_q[0];
    busy          = in_shift;
    done          = (state_q == S_DONE);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (abort) state_d = S_IDLE;
               else if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      buf_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      tail_ones <= '0;
    end else if (state_q == S_IDLE && start) begin
      rem_q     <= '0;
      cnt_q     <= '0;
      tail_ones <= '0;
    end else if (in_shift) begin
      // a refill on the last bit of a word overrides the shift of the old word
      if (abort || last_bit) begin
        rem_q <= '0;
      end else if (accept) begin
        buf_q <= word_data;
        rem_q <= REM_FULL;
      end else if (ccff_shift_en) begin
        buf_q <= buf_q >> 1;
        rem_q <= rem_q - REM_ONE;
      end
      if (ccff_shift_en) begin
        cnt_q     <= cnt_q + CNT_W'(1);
        tail_ones <= tail_ones + CNT_W'(ccff_tail);
      end
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader with a behavioural 65-flop chain model.
module tb_ccff_bitstream_loader;
  localparam int CHAIN_LEN = 65;
  localparam int WORD_W    = 8;
  localparam int CNT_W     = 16;
  // chain after loading words 0x01..0x09: MSB (mode bit) = first bit shifted
  localparam logic [CHAIN_LEN-1:0] FULL_CHAIN =
    65'b10000000_01000000_11000000_00100000_10100000_01100000_11100000_00010000_1;

  logic              prog_clk = 1'b0;
  logic              pReset = 1'b0;
  logic              start = 1'b0, abort = 1'b0, word_valid = 1'b0;
  logic [WORD_W-1:0] word_data = '0;
  logic              word_ready, ccff_head, ccff_shift_en, ccff_tail, busy, done;
  logic [CNT_W-1:0]  tail_ones;

  ccff_bitstream_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .start(start), .abort(abort),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
    .busy(busy), .done(done), .tail_ones(tail_ones));

  always #5 prog_clk = ~prog_clk;

  // chain model: bit 0 nearest head, tail is the top bit
  logic [CHAIN_LEN-1:0] chain;
  logic [CHAIN_LEN-1:0] preload_val = '0;
  logic                 preload = 1'b0;
  always @(posedge prog_clk) begin
    if (preload)            chain <= preload_val;
    else if (ccff_shift_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
  end
  assign ccff_tail = chain[CHAIN_LEN-1];

  int checks = 0, errors = 0;
  logic [WORD_W-1:0] wq[$];
  int  cyc = 0;
  int  sp1 = -1, sp2 = -1, sp3 = -1, abort_at = -1, stall_start = -1, stall_len = 0;
  bit  feed_en = 1'b0;
  int  nshift, first_sh, last_sh, ndone, done_cyc, gaps, head_bad;
  bit  acc;

  task automatic apply_inputs();
    start      = (cyc == sp1) || (cyc == sp2) || (cyc == sp3);
    abort      = (cyc == abort_at);
    word_valid = feed_en && (wq.size() > 0) &&
                 !(cyc >= stall_start && cyc < stall_start + stall_len);
    word_data  = (wq.size() > 0) ? wq[0] : '0;
  endtask

  task automatic new_run();
    nshift = 0; first_sh = -1; last_sh = -1; ndone = 0; done_cyc = -1;
    gaps = 0; head_bad = 0; cyc = 0;
    apply_inputs();
  endtask

  // observe cycle cyc mid-cycle, cross its ending edge, drive cycle cyc+1
  task automatic tick();
    @(negedge prog_clk);
    acc = word_valid && word_ready;
    if (ccff_shift_en) begin
      nshift++;
      if (first_sh < 0) first_sh = cyc;
      last_sh = cyc;
    end else begin
      if (ccff_head) head_bad++;
      if (busy && first_sh >= 0) gaps++;
    end
    if (done) begin ndone++; done_cyc = cyc; end
    @(posedge prog_clk);
    #1;
    if (acc) void'(wq.pop_front());
    cyc++;
    apply_inputs();
  endtask

  task automatic clear_stim();
    sp1 = -1; sp2 = -1; sp3 = -1; abort_at = -1; stall_start = -1; stall_len = 0;
    feed_en = 1'b0; wq.delete();
  endtask

  task automatic fill(input bit zeros);
    wq.delete();
    for (int i = 0; i < 9; i++) wq.push_back(zeros ? 8'h00 : 8'(i + 1));
    feed_en = 1'b1;
  endtask

  task automatic preload_chain(input logic [CHAIN_LEN-1:0] v);
    preload_val = v; preload = 1'b1;
    @(posedge prog_clk); #1;
    preload = 1'b0;
  endtask

  task automatic test_reset();
    preload_chain('0);
    checks++;
    if ({busy, done, word_ready, ccff_shift_en, ccff_head} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 00000",
                         {busy, done, word_ready, ccff_shift_en, ccff_head});
    end
    checks++;
    if (tail_ones !== '0) begin
      errors++; $display("FAIL reset_tail_ones: got %0d expected 0", tail_ones);
    end
    pReset = 1'b1;
    clear_stim(); wq.push_back(8'hFF); wq.push_back(8'hFF); feed_en = 1'b1; sp1 = 0;
    new_run();
    repeat (5) tick();
    checks++;
    if ({busy, ccff_shift_en} !== 2'b11) begin
      errors++; $display("FAIL pre_reset_shifting: got %b expected 11", {busy, ccff_shift_en});
    end
    pReset = 1'b0;
    #1;
    checks++;
    if ({busy, done, word_ready, ccff_shift_en, ccff_head} !== 5'b0 || tail_ones !== '0) begin
      errors++; $display("FAIL midstream_reset: got %b/%0d expected 00000/0",
                         {busy, done, word_ready, ccff_shift_en, ccff_head}, tail_ones);
    end
    #2;
    pReset = 1'b1;
    sp1 = -1;
    new_run();
    repeat (10) tick();
    checks++;
    if (nshift !== 0 || busy !== 1'b0 || word_ready !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: got shifts %0d busy %b ready %b expected 0 0 0",
                         nshift, busy, word_ready);
    end
    clear_stim();
  endtask

  task automatic test_full_load();
    preload_chain('0);
    clear_stim(); fill(1'b0); sp1 = 0;
    new_run();
    repeat (75) tick();
    checks++;
    if (nshift !== 65 || first_sh !== 2 || last_sh !== 66) begin
      errors++; $display("FAIL full_shift_window: got %0d shifts %0d..%0d expected 65 shifts 2..66",
                         nshift, first_sh, last_sh);
    end
    checks++;
    if (ndone !== 1 || done_cyc !== 67) begin
      errors++; $display("FAIL full_done: got %0d pulses at %0d expected 1 at 67", ndone, done_cyc);
    end
    checks++;
    if (gaps !== 0 || head_bad !== 0) begin
      errors++; $display("FAIL full_contiguous: got gaps %0d head_bad %0d expected 0 0", gaps, head_bad);
    end
    checks++;
    if (chain !== FULL_CHAIN) begin
      errors++; $display("FAIL full_chain: got %h expected %h", chain, FULL_CHAIN);
    end
    checks++;
    if (chain[CHAIN_LEN-1] !== 1'b1 || chain[0] !== 1'b1) begin
      errors++; $display("FAIL mode_sram0: got %b%b expected 11", chain[CHAIN_LEN-1], chain[0]);
    end
    checks++;
    if (tail_ones !== 16'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL full_tail_busy: got %0d/%b expected 0/0", tail_ones, busy);
    end
    clear_stim();
  endtask

  task automatic test_stall();
    clear_stim(); fill(1'b0); sp1 = 0; stall_start = 33; stall_len = 3;
    new_run();
    repeat (78) tick();
    checks++;
    if (nshift !== 65 || gaps !== 3) begin
      errors++; $display("FAIL stall_shifts: got %0d shifts %0d gaps expected 65 shifts 3 gaps",
                         nshift, gaps);
    end
    checks++;
    if (ndone !== 1 || done_cyc !== 70) begin
      errors++; $display("FAIL stall_done: got %0d pulses at %0d expected 1 at 70", ndone, done_cyc);
    end
    checks++;
    if (chain !== FULL_CHAIN) begin
      errors++; $display("FAIL stall_chain: got %h expected %h", chain, FULL_CHAIN);
    end
    checks++;
    if (tail_ones !== 16'd14) begin
      errors++; $display("FAIL stall_tail_ones: got %0d expected 14", tail_ones);
    end
    clear_stim();
  endtask

  task automatic test_ignored_start();
    clear_stim(); fill(1'b0); sp1 = 0; sp2 = 10; sp3 = 67;
    new_run();
    repeat (75) tick();
    checks++;
    if (ndone !== 1 || done_cyc !== 67 || nshift !== 65) begin
      errors++; $display("FAIL ignored_start: got %0d done at %0d %0d shifts expected 1 at 67 65",
                         ndone, done_cyc, nshift);
    end
    checks++;
    if (tail_ones !== 16'd14 || busy !== 1'b0) begin
      errors++; $display("FAIL ignored_start_tail: got %0d/%b expected 14/0", tail_ones, busy);
    end
    clear_stim();
  endtask

  task automatic test_abort();
    clear_stim(); fill(1'b0); sp1 = 0; abort_at = 22;
    new_run();
    repeat (24) tick();
    checks++;
    if (nshift !== 20 || ndone !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_stop: got %0d shifts %0d done busy %b expected 20 0 0",
                         nshift, ndone, busy);
    end
    checks++;
    if (tail_ones !== 16'd4) begin
      errors++; $display("FAIL abort_tail_ones: got %0d expected 4", tail_ones);
    end
    repeat (5) tick();
    checks++;
    if (tail_ones !== 16'd4 || nshift !== 20) begin
      errors++; $display("FAIL abort_frozen: got %0d/%0d expected 4/20", tail_ones, nshift);
    end
    clear_stim(); fill(1'b0); sp1 = 0; abort_at = 0;
    new_run();
    tick();
    checks++;
    if (busy !== 1'b1 || tail_ones !== 16'd0) begin
      errors++; $display("FAIL restart_cleared: got busy %b tail %0d expected 1 0", busy, tail_ones);
    end
    repeat (74) tick();
    checks++;
    if (ndone !== 1 || done_cyc !== 67 || nshift !== 65 || chain !== FULL_CHAIN) begin
      errors++; $display("FAIL restart_load: got %0d done at %0d %0d shifts chain %h expected 1 at 67 65 %h",
                         ndone, done_cyc, nshift, chain, FULL_CHAIN);
    end
    checks++;
    if (tail_ones !== 16'd14) begin
      errors++; $display("FAIL restart_tail_ones: got %0d expected 14", tail_ones);
    end
    clear_stim();
  endtask

  task automatic test_popcount();
    preload_chain('1);
    clear_stim(); fill(1'b1); sp1 = 0;
    new_run();
    repeat (75) tick();
    checks++;
    if (tail_ones !== 16'd65 || chain !== '0 || done_cyc !== 67) begin
      errors++; $display("FAIL popcount_ones: got %0d chain %h done %0d expected 65 0 67",
                         tail_ones, chain, done_cyc);
    end
    clear_stim(); fill(1'b1); sp1 = 0;
    new_run();
    repeat (75) tick();
    checks++;
    if (tail_ones !== 16'd0 || ndone !== 1) begin
      errors++; $display("FAIL popcount_zeros: got %0d/%0d expected 0/1", tail_ones, ndone);
    end
    clear_stim();
  endtask

  initial begin
    #1;
    test_reset();
    test_full_load();
    test_stall();
    test_ignored_start();
    test_abort();
    test_popcount();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccff_bitstream_loader.md
# ccff_bitstream_loader

Serializes configuration words onto a configuration-chain head (`ccff_head`) for logic tiles such as the fractured-LUT6 tile, whose chain holds 64 LUT SRAM bits plus 1 mode bit. It accepts parallel words over a valid/ready handshake and emits exactly `CHAIN_LEN` bits with a matching per-bit shift enable, which the clock gate uses to stall the chain. While loading, it counts the ones that leave on `ccff_tail`. That count is a popcount check of the configuration being replaced.

## Interface
Parameters:
- `CHAIN_LEN`, 65, number of chain flops to load (64 sram + 1 mode)
- `WORD_W`, 8, input word width
- `CNT_W`, 16, width of bit counter and `tail_ones`; must satisfy 2^CNT_W > CHAIN_LEN

Ports:
- `prog_clk`  in  1  programming clock; the only clock
- `pReset`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a load; sampled only in IDLE
- `abort`  in  1  synchronous cancel of a load in progress
- `word_data`  in  WORD_W  configuration word; bit 0 is shifted first
- `word_valid`  in  1  `word_data` is valid
- `word_ready`  out  1  loader accepts `word_data` this cycle
- `ccff_head`  out  1  serial bit to chain head
- `ccff_shift_en`  out  1  chain shifts at this `prog_clk` rising edge
- `ccff_tail`  in  1  chain tail bit
- `busy`  out  1  state is SHIFT
- `done`  out  1  one-cycle pulse when the load is complete
- `tail_ones`  out  CNT_W  ones sampled on `ccff_tail` during the current or last load

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE → SHIFT when `start`=1.
  - On that edge: bit counter := 0, `tail_ones` := 0, word buffer emptied.
- SHIFT, word buffer:
  - The buffer is a WORD_W shift register plus a remaining-bits count.
  - `word_ready` = SHIFT && !`abort` && (buffer empty || (remaining==1 && `ccff_shift_en`)).
  - This gives back-to-back streaming with no bubble.
  - Acceptance (`word_valid` && `word_ready`) loads `word_data` and sets remaining := WORD_W.
- SHIFT, shifting:
  - `ccff_shift_en` = SHIFT && buffer non-empty && bit counter < CHAIN_LEN.
  - `ccff_head` = buffer bit 0 (combinational). It is 0 whenever `ccff_shift_en`=0.
  - On each shift edge: buffer shifts right, remaining decrements, bit counter increments, and `tail_ones` += `ccff_tail`.
- SHIFT → DONE on the edge where the bit counter reaches CHAIN_LEN.
  - Unused bits of the final word are discarded. For 65/8 that is bits 7:1 of word 8.
  - `word_ready` is 0 in the cycle of the final shift, because the counter is at its limit.
- DONE: `done`=1 for one cycle, then the state returns to IDLE. `tail_ones` holds its value until the next `start`.
- Bit ordering: the first bit shifted lands at the chain position farthest from head (the mode bit). The last bit lands at sram[0].
- `abort` in SHIFT: next state is IDLE, the buffer is emptied, and no `done` is produced. The chain is left partially loaded. `tail_ones` holds its partial value.
- `start` in SHIFT or DONE: ignored.
- `abort` in IDLE: ignored.
- `start` and `abort` together in IDLE: `start` wins.
- A stall (buffer empty, no valid word) holds `ccff_shift_en` at 0. The chain does not move and no counters change.
- Reset values: state IDLE; `word_ready`, `ccff_head`, `ccff_shift_en`, `busy`, `done` all 0; `tail_ones` 0; buffer empty; counter 0. Reset assertion during SHIFT forces these values immediately.

## Timing
- `start` sampled at edge 0: SHIFT begins in cycle 1 and `word_ready`=1 in cycle 1.
- Word accepted at the edge ending cycle k: its bits appear on `ccff_head` with `ccff_shift_en`=1 in cycles k+1 … k+WORD_W.
- With continuous valid words, the load takes CHAIN_LEN consecutive shift cycles (cycles 2–66 for defaults). `done` is 1 in cycle 67, and `busy` is 0 from cycle 67.
- `ccff_tail` is sampled at the same edge the chain shifts. This captures the old tail bit.
- Each stalled cycle delays `done` by exactly one cycle.

## Test plan
- Reset: hold `pReset`=0 mid-stream → all outputs 0 immediately. After release with no `start`, the block stays idle and `ccff_shift_en` is never asserted.
- Full load: `start` at cycle 0, then 9 words 0x01,0x02,…,0x09 presented continuously.
  - Required: 65 contiguous shift cycles (2–66) and `done` in cycle 67 only.
  - A reference chain model shows the mode bit = 1 (word 0 bit 0) and sram[0] = word 8 bit 0 = 1.
- Stall: deassert `word_valid` for 3 cycles after word 3 → `ccff_shift_en` is low for exactly 3 cycles, `done` arrives in cycle 70, and chain contents are identical to the full-load case.
- Popcount: chain preloaded all ones, then a load of all-zero words → `tail_ones`=65. A second load with zero words → `tail_ones`=0.
- Abort: assert `abort` after 20 shifts → IDLE next cycle, no `done`, `tail_ones` frozen, and a second `start` begins a fresh load with counters cleared.
- Ignored `start`: pulse `start` in cycles 10 and 67 → no effect on counter, `done`, or `tail_ones`.
